// File: rtl/led_breath_pwm.sv
// Breathing LED driver: a PWM duty cycle that ramps up, holds, ramps down and holds again.
// Brightness steps are only applied on a PWM period boundary so the LED never glitches.
module led_breath_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 375000,
  parameter int HOLD_STEPS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          state,
  output logic                breath_done
);

  localparam logic [1:0] HOLD_LO = 2'd0;
  localparam logic [1:0] RAMP_UP = 2'd1;
  localparam logic [1:0] HOLD_HI = 2'd2;
  localparam logic [1:0] RAMP_DN = 2'd3;

  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MIN  = '0;
  localparam logic [31:0]         STEP_LAST = 32'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [31:0]         step_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                pend;

  logic                wrap;
  logic                tick;
  logic                apply;
  logic                hold_last;

  logic [1:0]          state_nxt;
  logic [PWM_BITS-1:0] duty_nxt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic                done_nxt;

  assign wrap      = (pwm_cnt == DUTY_MAX);
  assign tick      = (step_cnt == STEP_LAST);
  assign apply     = wrap & (pend | tick);
  assign hold_last = (hold_cnt == HOLD_LAST);

  // One brightness step per apply; at the ends of the ramps the state moves on instead.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    if (apply) begin
      case (state)
        HOLD_LO: begin
          if (hold_last) begin
            state_nxt = RAMP_UP;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        RAMP_UP: begin
          if (duty == DUTY_MAX) begin
            state_nxt = HOLD_HI;
            hold_nxt  = '0;
          end else begin
            duty_nxt = duty + 1'b1;
          end
        end
        HOLD_HI: begin
          if (hold_last) begin
            state_nxt = RAMP_DN;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        default: begin
          if (duty == DUTY_MIN) begin
            state_nxt = HOLD_LO;
            hold_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            duty_nxt = duty - 1'b1;
          end
        end
      endcase
    end
  end

  // Disable behaves like a synchronous reset so re-enabling restarts the pattern cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= '0;
      step_cnt    <= '0;
      hold_cnt    <= '0;
      pend        <= 1'b0;
      state       <= HOLD_LO;
      duty        <= '0;
      led         <= 1'b0;
      breath_done <= 1'b0;
    end else if (!en) begin
      pwm_cnt     <= '0;
      step_cnt    <= '0;
      hold_cnt    <= '0;
      pend        <= 1'b0;
      state       <= HOLD_LO;
      duty        <= '0;
      led         <= 1'b0;
      breath_done <= 1'b0;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      step_cnt    <= tick ? 32'd0 : step_cnt + 32'd1;
      // Ticks arriving mid-period collapse into a single pending step.
      pend        <= (pend & ~apply) | tick;
      hold_cnt    <= hold_nxt;
      state       <= state_nxt;
      duty        <= duty_nxt;
      led         <= (pwm_cnt < duty);
      breath_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Scoreboard bench for led_breath_pwm using a closed-form model of the breath sequence.
module tb_led_breath_pwm;

  localparam int PWM_BITS   = 3;
  localparam int HOLD_STEPS = 2;
  localparam int PER        = 1 << PWM_BITS;
  localparam int DMAX       = PER - 1;
  localparam int BREATH     = 2 * HOLD_STEPS + 2 * DMAX + 2;
  localparam int PERIOD     = 2 * (PER + HOLD_STEPS) * PER;

  typedef struct {
    logic       led;
    logic [2:0] duty;
    logic [1:0] state;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       led_a, led_b;
  logic [2:0] duty_a, duty_b;
  logic [1:0] state_a, state_b;
  logic       done_a, done_b;

  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   cyc = 0;
  int   last_a, last_b;
  bit   valid_a = 0, valid_b = 0;
  int   per_a = 0, per_b = 0;

  led_breath_pwm #(.PWM_BITS(PWM_BITS), .STEP_DIV(4), .HOLD_STEPS(HOLD_STEPS)) dut_a (
    .clk(clk), .rst(rst), .en(en), .led(led_a), .duty(duty_a),
    .state(state_a), .breath_done(done_a)
  );

  // Same pattern with a tick every cycle: excess ticks must merge to one step per period.
  led_breath_pwm #(.PWM_BITS(PWM_BITS), .STEP_DIV(1), .HOLD_STEPS(HOLD_STEPS)) dut_b (
    .clk(clk), .rst(rst), .en(en), .led(led_b), .duty(duty_b),
    .state(state_b), .breath_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dutyAt(input int n);
    int r;
    r = n % BREATH;
    if (r < HOLD_STEPS) return 0;
    if (r < HOLD_STEPS + DMAX + 1) return r - HOLD_STEPS;
    if (r < 2 * HOLD_STEPS + DMAX + 1) return DMAX;
    return DMAX - (r - (2 * HOLD_STEPS + DMAX + 1));
  endfunction

  function automatic int stateAt(input int n);
    int r;
    r = n % BREATH;
    if (r < HOLD_STEPS) return 0;
    if (r < HOLD_STEPS + DMAX + 1) return 1;
    if (r < 2 * HOLD_STEPS + DMAX + 1) return 2;
    return 3;
  endfunction

  // Expected outputs after enabled edge c (c=0 is the first edge after release).
  function automatic exp_t model(input int c);
    exp_t x;
    int   n_now;
    int   n_prev;
    n_now   = (c + 1) / PER;
    n_prev  = c / PER;
    x.duty  = 3'(dutyAt(n_now));
    x.state = 2'(stateAt(n_now));
    x.led   = ((c % PER) < dutyAt(n_prev));
    x.done  = (n_now > 0) && (n_now % BREATH == 0) && ((c + 1) % PER == 0);
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic e);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    if (r || !e) begin
      x = '{led: 1'b0, duty: 3'd0, state: 2'd0, done: 1'b0};
      k = 0;
    end else begin
      x = model(k);
      k++;
    end
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst || !en) begin
      valid_a = 0;
      valid_b = 0;
    end
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      checkOutput("led_a",   32'(led_a),   32'(e_mon.led));
      checkOutput("duty_a",  32'(duty_a),  32'(e_mon.duty));
      checkOutput("state_a", 32'(state_a), 32'(e_mon.state));
      checkOutput("done_a",  32'(done_a),  32'(e_mon.done));
      checkOutput("led_b",   32'(led_b),   32'(e_mon.led));
      checkOutput("duty_b",  32'(duty_b),  32'(e_mon.duty));
      checkOutput("state_b", 32'(state_b), 32'(e_mon.state));
      checkOutput("done_b",  32'(done_b),  32'(e_mon.done));
    end
    if (!rst && en && done_a === 1'b1) begin
      if (valid_a) begin
        checkOutput("period_a", 32'(cyc - last_a), 32'(PERIOD));
        per_a++;
      end
      last_a  = cyc;
      valid_a = 1;
    end
    if (!rst && en && done_b === 1'b1) begin
      if (valid_b) begin
        checkOutput("period_b", 32'(cyc - last_b), 32'(PERIOD));
        per_b++;
      end
      last_b  = cyc;
      valid_b = 1;
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    $display("[TB] reset hold");
    repeat (20) applyStimulus(1'b1, 1'b1);

    $display("[TB] free run from reset release");
    repeat (490) applyStimulus(1'b0, 1'b1);

    $display("[TB] en drop at duty 5 then restart");
    repeat (3) applyStimulus(1'b0, 1'b0);
    repeat (60) applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    repeat (120) applyStimulus(1'b0, 1'b1);

    $display("[TB] async reset mid ramp down");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_led_a",   32'(led_a),   32'd0);
    checkOutput("async_duty_a",  32'(duty_a),  32'd0);
    checkOutput("async_state_a", 32'(state_a), 32'd0);
    checkOutput("async_done_a",  32'(done_a),  32'd0);
    checkOutput("async_duty_b",  32'(duty_b),  32'd0);
    checkOutput("async_state_b", 32'(state_b), 32'd0);
    repeat (5) applyStimulus(1'b1, 1'b1);
    repeat (170) applyStimulus(1'b0, 1'b1);

    @(negedge clk);
    checkOutput("sb_drain", 32'(q.size()), 32'd0);
    checkOutput("periods_a", 32'(per_a), 32'd2);
    checkOutput("periods_b", 32'(per_b), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
